// File: rtl/sisc_fetch_unit.sv
// SISC instruction-fetch stage: program counter, instruction register, IR field decode,
// branch-target arithmetic and a stall handshake for slow instruction memory.
//
// state | meaning
// IDLE  | executes control-FSM commands; a fetch that sees im_ready completes this cycle
// WAIT  | fetch issued without im_ready; the PC command is parked in pending_*
module sisc_fetch_unit #(
  parameter int PC_W  = 16,
  parameter int IR_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_f,
  input  logic             pc_rst,
  input  logic             pc_write,
  input  logic             pc_sel,
  input  logic             br_sel,
  input  logic             ir_load,
  input  logic [IR_W-1:0]  im_rdata,
  input  logic             im_ready,
  output logic [PC_W-1:0]  im_addr,
  output logic [PC_W-1:0]  pc,
  output logic [IR_W-1:0]  ir,
  output logic [3:0]       opcode,
  output logic [3:0]       mm,
  output logic [3:0]       rd,
  output logic [3:0]       rs,
  output logic [3:0]       rt,
  output logic [15:0]      imm,
  output logic             fetch_stall,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [IR_W-1:0] ir_nxt;
  logic            cnt_inc;
  logic            pending_pc, pending_sel, pending_br;
  logic            pending_pc_nxt, pending_sel_nxt, pending_br_nxt;

  assign opcode      = ir[31:28];
  assign mm          = ir[27:24];
  assign rd          = ir[23:20];
  assign rs          = ir[19:16];
  assign rt          = ir[15:12];
  assign imm         = ir[15:0];
  assign im_addr     = pc;
  assign fetch_stall = (state == WAIT);

  // Branch arithmetic always uses the registered IR, even when IR reloads this cycle.
  function automatic logic [PC_W-1:0] pc_target(input logic sel, input logic br);
    if (!sel)    return pc + PC_W'(1);
    else if (br) return PC_W'(imm);
    else         return pc + PC_W'(imm);
  endfunction

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    ir_nxt          = ir;
    cnt_inc         = 1'b0;
    pending_pc_nxt  = pending_pc;
    pending_sel_nxt = pending_sel;
    pending_br_nxt  = pending_br;
    if (pc_rst) begin
      state_nxt       = IDLE;
      pc_nxt          = '0;
      ir_nxt          = '0;
      pending_pc_nxt  = 1'b0;
      pending_sel_nxt = 1'b0;
      pending_br_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ir_load && !im_ready) begin
            state_nxt       = WAIT;
            pending_pc_nxt  = pc_write;
            pending_sel_nxt = pc_sel;
            pending_br_nxt  = br_sel;
          end else begin
            if (pc_write) pc_nxt = pc_target(pc_sel, br_sel);
            if (ir_load) begin
              ir_nxt  = im_rdata;
              cnt_inc = 1'b1;
            end
          end
        end
        WAIT: begin
          if (im_ready) begin
            state_nxt = IDLE;
            ir_nxt    = im_rdata;
            cnt_inc   = 1'b1;
            if (pending_pc) pc_nxt = pc_target(pending_sel, pending_br);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state       <= IDLE;
      pc          <= '0;
      ir          <= '0;
      instr_count <= '0;
      pending_pc  <= 1'b0;
      pending_sel <= 1'b0;
      pending_br  <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      ir          <= ir_nxt;
      pending_pc  <= pending_pc_nxt;
      pending_sel <= pending_sel_nxt;
      pending_br  <= pending_br_nxt;
      // Saturating: the count sticks at all-ones rather than wrapping.
      if (cnt_inc && (instr_count != '1)) instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Self-checking bench for sisc_fetch_unit: directed test-plan steps and randomized
// cycles, all compared against a cycle-level behavioural model of the fetch rules.
module tb_sisc_fetch_unit;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst_f, pc_rst, pc_write, pc_sel, br_sel, ir_load, im_ready;
  logic [31:0] im_rdata;
  logic [15:0] im_addr, pc, imm;
  logic [31:0] ir;
  logic [3:0]  opcode, mm, rd, rs, rt;
  logic        fetch_stall;
  logic [CNT_W-1:0] instr_count;

  sisc_fetch_unit #(.PC_W(16), .IR_W(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_f(rst_f), .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel),
    .br_sel(br_sel), .ir_load(ir_load), .im_rdata(im_rdata), .im_ready(im_ready),
    .im_addr(im_addr), .pc(pc), .ir(ir), .opcode(opcode), .mm(mm), .rd(rd), .rs(rs),
    .rt(rt), .imm(imm), .fetch_stall(fetch_stall), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // behavioural model
  int unsigned m_pc, m_cnt;
  logic [31:0] m_ir;
  bit          m_waiting, m_ppc, m_psel, m_pbr;

  function automatic int unsigned tgt(bit sel, bit br);
    int unsigned off;
    off = m_ir & 32'hFFFF;
    if (!sel) return (m_pc + 1) % 65536;
    if (br)   return off;
    return (m_pc + off) % 65536;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_cnt = 0; m_ir = '0; m_waiting = 0; m_ppc = 0; m_psel = 0; m_pbr = 0;
  endtask

  task automatic model_fetch(logic [31:0] data);
    m_ir = data;
    if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
  endtask

  task automatic model_step();
    if (pc_rst) begin
      m_pc = 0; m_ir = '0; m_waiting = 0; m_ppc = 0; m_psel = 0; m_pbr = 0;
    end else if (m_waiting) begin
      if (im_ready) begin
        if (m_ppc) m_pc = tgt(m_psel, m_pbr);
        model_fetch(im_rdata);
        m_waiting = 0;
      end
    end else if (ir_load && !im_ready) begin
      m_waiting = 1; m_ppc = pc_write; m_psel = pc_sel; m_pbr = br_sel;
    end else begin
      if (pc_write) m_pc = tgt(pc_sel, br_sel);
      if (ir_load) model_fetch(im_rdata);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pc", 32'(pc), m_pc);
    chk("im_addr", 32'(im_addr), m_pc);
    chk("ir", ir, m_ir);
    chk("opcode", 32'(opcode), 32'(m_ir[31:28]));
    chk("mm", 32'(mm), 32'(m_ir[27:24]));
    chk("rd", 32'(rd), 32'(m_ir[23:20]));
    chk("rs", 32'(rs), 32'(m_ir[19:16]));
    chk("rt", 32'(rt), 32'(m_ir[15:12]));
    chk("imm", 32'(imm), 32'(m_ir[15:0]));
    chk("fetch_stall", 32'(fetch_stall), 32'(m_waiting));
    chk("instr_count", 32'(instr_count), m_cnt);
  endtask

  task automatic cyc(input logic prst, input logic pw, input logic ps, input logic bs,
                     input logic il, input logic [31:0] data, input logic rdy);
    pc_rst = prst; pc_write = pw; pc_sel = ps; br_sel = bs; ir_load = il;
    im_rdata = data; im_ready = rdy;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  int stall_cycles;
  logic [CNT_W-1:0] saved_cnt;

  initial begin
    rst_f = 1'b0; pc_rst = 0; pc_write = 0; pc_sel = 0; br_sel = 0; ir_load = 0;
    im_rdata = '0; im_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_f = 1'b1;

    // sequential fetch
    cyc(0, 1, 0, 0, 1, 32'h81230000, 1);
    cyc(0, 1, 0, 0, 1, 32'h10450007, 1);
    cyc(0, 1, 0, 0, 1, 32'h40000020, 1);
    chk("seq_pc", 32'(pc), 32'h3);
    chk("seq_opcode", 32'(opcode), 32'h4);
    chk("seq_imm", 32'(imm), 32'h0020);
    chk("seq_count", 32'(instr_count), 32'd3);

    // absolute branch
    cyc(0, 1, 1, 1, 0, 32'h0, 1);
    chk("abs_pc", 32'(pc), 32'h0020);
    chk("abs_ir", ir, 32'h40000020);

    // relative branch backwards, then increment wrap
    cyc(1, 0, 0, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 0, 1, 32'h0000FFF8, 1);
    repeat (5) cyc(0, 1, 0, 0, 0, 32'h0, 0);
    chk("rel_start_pc", 32'(pc), 32'h0005);
    cyc(0, 1, 1, 0, 0, 32'h0, 0);
    chk("rel_pc", 32'(pc), 32'hFFFD);
    repeat (2) cyc(0, 1, 0, 0, 0, 32'h0, 0);
    chk("pre_wrap_pc", 32'(pc), 32'hFFFF);
    cyc(0, 1, 0, 0, 0, 32'h0, 0);
    chk("wrap_pc", 32'(pc), 32'h0000);

    // stall with pc_write toggling inside WAIT
    stall_cycles = 0;
    cyc(0, 1, 0, 0, 1, 32'hBAD0BAD0, 0);
    stall_cycles += int'(fetch_stall);
    cyc(0, 0, 1, 1, 1, 32'hBAD0BAD1, 0);
    stall_cycles += int'(fetch_stall);
    cyc(0, 1, 1, 0, 0, 32'hBAD0BAD2, 0);
    stall_cycles += int'(fetch_stall);
    chk("stall_pc_held", 32'(pc), 32'h0000);
    cyc(0, 0, 1, 1, 0, 32'h20120004, 1);
    chk("stall_cycles", stall_cycles, 3);
    chk("stall_ir", ir, 32'h20120004);
    chk("stall_pc", 32'(pc), 32'h0001);
    chk("stall_done", 32'(fetch_stall), 32'h0);

    // pc_rst mid-WAIT beats completion
    cyc(0, 0, 0, 0, 1, 32'h00000010, 1);
    cyc(0, 1, 1, 1, 0, 32'h0, 0);
    chk("pre_wait_pc", 32'(pc), 32'h0010);
    cyc(0, 1, 0, 0, 1, 32'h11111111, 0);
    saved_cnt = instr_count;
    cyc(1, 0, 0, 0, 0, 32'hDEADBEEF, 1);
    chk("prst_pc", 32'(pc), 32'h0);
    chk("prst_ir", ir, 32'h0);
    chk("prst_stall", 32'(fetch_stall), 32'h0);
    chk("prst_count", 32'(instr_count), 32'(saved_cnt));

    // asynchronous reset mid-WAIT
    cyc(0, 1, 0, 0, 1, 32'h33333333, 1);
    cyc(0, 1, 0, 0, 1, 32'h44444444, 0);
    chk("async_pre_stall", 32'(fetch_stall), 32'h1);
    @(negedge clk);
    rst_f = 1'b0;
    #1;
    model_reset();
    check_all();
    im_ready = 1; im_rdata = 32'h55555555;
    @(negedge clk);
    rst_f = 1'b1;
    cyc(0, 0, 0, 0, 0, 32'h55555555, 1);
    chk("async_ignored_ir", ir, 32'h0);

    // saturation of the fetch counter
    for (int i = 0; i < CNT_MAX + 3; i++) cyc(0, 1, 0, 0, 1, 32'h0100_0000 + i, 1);
    chk("count_sat", 32'(instr_count), CNT_MAX);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), $urandom, ($urandom_range(0, 9) < 6));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
